// File: rtl/route_lock_ctrl_pkg.sv
// Shared definitions for the route locking controller.
// Holds the controller state enumeration, the state and timer widths and
// the packed bundle of registered control outputs.
package route_lock_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_PERMIT = 3'd1,
    ST_SETTING     = 3'd2,
    ST_LOCKED      = 3'd3,
    ST_OCCUPIED    = 3'd4,
    ST_RELEASING   = 3'd5,
    ST_FAULT       = 3'd6
  } state_t;

  typedef struct packed {
    logic route_req;
    logic route_locked;
    logic signal_clear;
    logic fault;
  } ctrl_out_t;

endpackage

// File: rtl/route_timer.sv
// Loadable saturating down-counter shared by point setting, approach-lock
// release and the optional permit watchdog.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (count -> 0)
//   load        load count with load_val (wins over dec)
//   load_val    value to load
//   dec         decrement by one, holding at zero
//   zero_c      count is zero (combinational from the count register)
module route_timer
  import route_lock_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] count;

  // Counter register: never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/route_lock_ctrl.sv
// Route locking controller: claims a route from the interlock, waits for
// the points to set, holds the route locked while the signal may clear,
// and releases it after train passage or a timed approach-lock release.
// Optional permit watchdog enabled by defining ROUTE_LOCK_WATCHDOG_EN.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req            operator route request (level, rising edge used)
//   i_cancel         operator cancel
//   i_permit         interlock grant for this route
//   i_track_clear    all route track circuits clear
//   i_occupied       train has entered the route
//   i_fault_ack      maintainer fault acknowledge
//   o_route_req      route claim into the interlock
//   o_route_locked   points set and route locked
//   o_signal_clear   entry signal proceed aspect
//   o_fault          controller in FAULT
//   o_state          current state encoding (debug)
module route_lock_ctrl
  import route_lock_ctrl_pkg::*;
#(
  parameter int unsigned SET_CYCLES     = 8,
  parameter int unsigned RELEASE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req,
  input  logic               i_cancel,
  input  logic               i_permit,
  input  logic               i_track_clear,
  input  logic               i_occupied,
  input  logic               i_fault_ack,
  output logic               o_route_req,
  output logic               o_route_locked,
  output logic               o_signal_clear,
  output logic               o_fault,
  output logic [STATE_W-1:0] o_state
);

  // Elaboration-time range checks on the timing parameters.
  if ((SET_CYCLES == 0) || (SET_CYCLES > 65535)) begin : g_bad_set
    $error("SET_CYCLES must be in 1..65535");
  end
  if ((RELEASE_CYCLES == 0) || (RELEASE_CYCLES > 65535)) begin : g_bad_release
    $error("RELEASE_CYCLES must be in 1..65535");
  end
  if ((TIMEOUT_CYCLES == 0) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  // Timer loads are N-1 so the exit test on zero lands N clocks after loading.
  localparam logic [CNT_W-1:0] SET_LOAD = CNT_W'(SET_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LOAD = CNT_W'(RELEASE_CYCLES - 1);
`ifdef ROUTE_LOCK_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t           state;
  state_t           state_nx;
  ctrl_out_t        outs;
  ctrl_out_t        outs_nx;
  logic             req_q;
  logic             armed;
  logic             req_edge_c;
  logic             tmr_load;
  logic             tmr_dec;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero_c;

  // Request edge detector; 'armed' masks the first clock after reset so a
  // request held high through reset is not taken as a new request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      req_q <= i_req;
      armed <= 1'b1;
    end
  end

  assign req_edge_c = i_req & ~req_q & armed;

  route_timer u_timer (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero_c   (tmr_zero_c)
  );

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      outs  <= '0;
    end else begin
      state <= state_nx;
      outs  <= outs_nx;
    end
  end

  // Next state, timer control and next outputs.
  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    outs_nx  = '0;

    case (state)
      ST_IDLE: begin
        if (req_edge_c && !i_cancel) begin
          state_nx = ST_WAIT_PERMIT;
`ifdef ROUTE_LOCK_WATCHDOG_EN
          tmr_load = 1'b1;
          tmr_val  = WD_LOAD;
`endif
        end
      end
      ST_WAIT_PERMIT: begin
        if (i_cancel) begin
          state_nx = ST_IDLE;
        end else if (i_permit) begin
          state_nx = ST_SETTING;
          tmr_load = 1'b1;
          tmr_val  = SET_LOAD;
        end
`ifdef ROUTE_LOCK_WATCHDOG_EN
        else if (tmr_zero_c) begin
          state_nx = ST_FAULT;
        end else begin
          tmr_dec = 1'b1;
        end
`endif
      end
      ST_SETTING: begin
        if (!i_permit || i_cancel) begin
          state_nx = ST_IDLE;
        end else if (tmr_zero_c) begin
          state_nx = ST_LOCKED;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_LOCKED: begin
        // Loss of grant is a safety fault and outranks everything;
        // train entry outranks an operator cancel.
        if (!i_permit) begin
          state_nx = ST_FAULT;
        end else if (i_occupied) begin
          state_nx = ST_OCCUPIED;
        end else if (i_cancel) begin
          state_nx = ST_RELEASING;
          tmr_load = 1'b1;
          tmr_val  = REL_LOAD;
        end
      end
      ST_OCCUPIED: begin
        // Train has left once occupancy drops with all track circuits clear.
        if (!i_occupied && i_track_clear) begin
          state_nx = ST_IDLE;
        end
      end
      ST_RELEASING: begin
        if (i_occupied) begin
          state_nx = ST_OCCUPIED;
        end else if (tmr_zero_c) begin
          state_nx = ST_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_FAULT: begin
        if (i_fault_ack && !i_occupied) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    case (state_nx)
      ST_WAIT_PERMIT, ST_SETTING: begin
        outs_nx.route_req = 1'b1;
      end
      ST_LOCKED, ST_OCCUPIED, ST_RELEASING: begin
        outs_nx.route_req    = 1'b1;
        outs_nx.route_locked = 1'b1;
      end
      ST_FAULT: begin
        outs_nx.fault = 1'b1;
      end
      default: begin
        outs_nx = '0;
      end
    endcase

    // Proceed aspect only while remaining in LOCKED with track and grant.
    outs_nx.signal_clear = (state == ST_LOCKED) && (state_nx == ST_LOCKED) &&
                           i_track_clear && i_permit;
  end

  assign o_route_req    = outs.route_req;
  assign o_route_locked = outs.route_locked;
  assign o_signal_clear = outs.signal_clear;
  assign o_fault        = outs.fault;
  assign o_state        = state;

endmodule

// File: tb/tb_route_lock_ctrl.sv
// Scoreboard bench for route_lock_ctrl: a timestamp-based reference model
// predicts the outputs after every clock, a monitor compares them.
module tb_route_lock_ctrl;

  localparam int unsigned SET_C = 8;
  localparam int unsigned REL_C = 16;
  localparam int unsigned TO_C  = 32;

  localparam int M_IDLE = 0, M_WAIT = 1, M_SET = 2, M_LOCK = 3,
                 M_OCC = 4, M_REL = 5, M_FAULT = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_req = 1'b0, i_cancel = 1'b0, i_permit = 1'b0;
  logic       i_track_clear = 1'b0, i_occupied = 1'b0, i_fault_ack = 1'b0;
  logic       o_route_req, o_route_locked, o_signal_clear, o_fault;
  logic [2:0] o_state;

  always #5 clk = ~clk;

  route_lock_ctrl #(
    .SET_CYCLES     (SET_C),
    .RELEASE_CYCLES (REL_C),
    .TIMEOUT_CYCLES (TO_C)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req          (i_req),
    .i_cancel       (i_cancel),
    .i_permit       (i_permit),
    .i_track_clear  (i_track_clear),
    .i_occupied     (i_occupied),
    .i_fault_ack    (i_fault_ack),
    .o_route_req    (o_route_req),
    .o_route_locked (o_route_locked),
    .o_signal_clear (o_signal_clear),
    .o_fault        (o_fault),
    .o_state        (o_state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       rq;
    logic       lk;
    logic       clr;
    logic       flt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: state plus the clock number at which it was entered.
  int   m_st = M_IDLE;
  int   m_t0 = 0;
  int   m_cyc = 0;
  logic m_prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, want);
    end
  endtask

  task automatic enter(input int st);
    m_st = st;
    m_t0 = m_cyc;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic edge_seen;
    int   prev_st;
    int   elapsed;
    exp_t e;
    m_cyc++;
    edge_seen  = i_req && !m_prev_req;
    m_prev_req = i_req;
    prev_st    = m_st;
    elapsed    = m_cyc - m_t0;
    case (m_st)
      M_IDLE:  if (edge_seen && !i_cancel) enter(M_WAIT);
      M_WAIT: begin
        if (i_cancel) enter(M_IDLE);
        else if (i_permit) enter(M_SET);
`ifdef ROUTE_LOCK_WATCHDOG_EN
        else if (elapsed >= int'(TO_C)) enter(M_FAULT);
`endif
      end
      M_SET: begin
        if (!i_permit || i_cancel) enter(M_IDLE);
        else if (elapsed >= int'(SET_C)) enter(M_LOCK);
      end
      M_LOCK: begin
        if (!i_permit) enter(M_FAULT);
        else if (i_occupied) enter(M_OCC);
        else if (i_cancel) enter(M_REL);
      end
      M_OCC:   if (!i_occupied && i_track_clear) enter(M_IDLE);
      M_REL: begin
        if (i_occupied) enter(M_OCC);
        else if (elapsed >= int'(REL_C)) enter(M_IDLE);
      end
      M_FAULT: if (i_fault_ack && !i_occupied) enter(M_IDLE);
      default: enter(M_IDLE);
    endcase
    e.st  = 3'(m_st);
    e.rq  = (m_st >= M_WAIT) && (m_st <= M_REL);
    e.lk  = (m_st >= M_LOCK) && (m_st <= M_REL);
    e.flt = (m_st == M_FAULT);
    e.clr = (prev_st == M_LOCK) && (m_st == M_LOCK) && i_track_clear && i_permit;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic req, input logic cancel, input logic permit,
                      input logic track, input logic occ, input logic ack);
    @(negedge clk);
    i_req = req; i_cancel = cancel; i_permit = permit;
    i_track_clear = track; i_occupied = occ; i_fault_ack = ack;
    model_step();
  endtask

  // Asynchronous reset: outputs must drop before any clock edge.
  task automatic do_reset(input logic req_level);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    i_req = req_level; i_cancel = 1'b0; i_permit = 1'b0;
    i_track_clear = 1'b0; i_occupied = 1'b0; i_fault_ack = 1'b0;
    #1;
    check("async_reset", 32'({o_state, o_route_req, o_route_locked, o_signal_clear, o_fault}), 32'(0));
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    m_st       = M_IDLE;
    m_t0       = 0;
    m_cyc      = 0;
    m_prev_req = req_level;
  endtask

  task automatic go_locked();
    step(0, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    repeat (SET_C + 1) step(1, 0, 1, 1, 0, 0);
  endtask

  // Monitor: one prediction per clock after reset release.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && (exp_q.size() > 0)) begin
        e = exp_q.pop_front();
        check("scoreboard",
              32'({o_state, o_route_req, o_route_locked, o_signal_clear, o_fault}),
              32'({e.st, e.rq, e.lk, e.clr, e.flt}));
      end
    end
  end

  initial begin : stimulus
    int lock_k;
    int rel_n;
    do_reset(1'b0);

    // Lock latency from WAIT_PERMIT entry, then signal clears a clock later.
    step(1, 0, 1, 1, 0, 0);
    lock_k = 0;
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, 1, 1, 0, 0);
      @(posedge clk);
      #1;
      if (o_route_locked) begin
        lock_k = k;
        break;
      end
    end
    check("lock_latency", 32'(lock_k), 32'(SET_C + 1));
    step(1, 0, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    check("clear_after_lock", 32'(o_signal_clear), 32'(1));

    // Occupied and cancel together: occupation wins.
    step(0, 1, 1, 1, 1, 0);
    @(posedge clk);
    #1;
    check("occ_wins_state", 32'(o_state), 32'(4));
    check("occ_wins_clear", 32'(o_signal_clear), 32'(0));
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);

    // Cancel from LOCKED: releasing for REL_C clocks, then idle.
    go_locked();
    step(0, 1, 1, 1, 0, 0);
    rel_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (o_state == 3'd5) rel_n++;
      else break;
      step(0, 0, 1, 1, 0, 0);
    end
    check("release_len", 32'(rel_n), 32'(REL_C));
    check("release_req_off", 32'(o_route_req), 32'(0));

    // Permit dropped mid-setting at count 3: abort without locking.
    step(0, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    repeat (4) step(1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    check("abort_state", 32'(o_state), 32'(0));
    check("abort_unlocked", 32'(o_route_locked), 32'(0));

    // Grant lost while locked: fault, ack blocked while occupied.
    go_locked();
    step(0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    check("permit_loss_fault", 32'(o_fault), 32'(1));
    step(0, 0, 1, 1, 1, 1);
    step(0, 0, 1, 1, 0, 1);
    go_locked();
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    do_reset(1'b1);

    // Request held high through reset is not an edge.
    repeat (3) step(1, 0, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    check("req_level_after_reset", 32'(o_state), 32'(0));
    step(0, 0, 1, 1, 0, 0);

    // Permit withheld: waits forever, or watchdog fault when enabled.
    step(1, 0, 0, 1, 0, 0);
    repeat (TO_C + 4) step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 99) < 40),
             1'($urandom_range(0, 99) < 4),
             1'($urandom_range(0, 99) < 96),
             1'($urandom_range(0, 99) < 85),
             1'($urandom_range(0, 99) < 8),
             1'($urandom_range(0, 99) < 30));
      end
    end

    @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
